alu4_acc_ctrl: RTL and testbench
================================

// Module: alu4_acc_ctrl
// PURPOSE
//  Upstream sequencer for alu4: buffers instructions {ld, op, b} in a small FIFO, drives alu4 with
//  a = accumulator, b = operand, and writes result and flags c/n/z/v back into registers.
//  Turns the combinational alu4 into a 4-bit accumulator datapath with a valid/ready front end.
//  Instantiates alu4 internally; alu4 op codes are fixed:
//  000 notA, 001 notB, 010 and, 011 or, 100 xor, 101 xnor, 110 sub (a-b), 111 add.
// PARAMETERS
//  FIFO_DEPTH  4  instruction FIFO entries; must be a power of 2, >= 2
//  FIFO_AW     2  pointer width = log2(FIFO_DEPTH)
// PORTS
//  clk        in   1  single clock; all state updates on its rising edge
//  reset      in   1  synchronous, active-high reset
//  in_valid   in   1  instruction offered
//  in_ready   out  1  FIFO can accept: !full && !reset (combinational)
//  in_ld      in   1  1 = load in_b into acc directly (op ignored); 0 = ALU op
//  in_op      in   3  alu4 op code
//  in_b       in   4  operand b / load value
//  hold       in   1  1 = FSM does not leave IDLE; an in-flight instruction still completes
//  acc        out  4  accumulator (registered)
//  c, n, z, v out  1  flag register (registered)
//  out_valid  out  1  one-cycle pulse, cycle after acc/flags update
//  busy       out  1  1 when state != IDLE or FIFO not empty
// BEHAVIOUR
//  - Reset: acc=0, c=n=z=v=0, out_valid=0, FIFO empty, pointers=0, state=IDLE.
//    Reset wins over every other event, including mid-instruction; the in-flight instruction is discarded.
//  - Push: on in_valid && in_ready, write {in_ld, in_op, in_b} at wr_ptr; wr_ptr++ (wraps mod FIFO_DEPTH).
//  - in_ready is low when full, even if a pop happens in the same cycle.
//  - Push and pop in the same cycle when not full: count unchanged.
//  - FSM states are IDLE, FETCH and EXEC:
//    IDLE  -> FETCH if count>0 && !hold; else stay in IDLE.
//    FETCH: pop head into op_r/b_r/ld_r; rd_ptr++; -> EXEC.
//    EXEC: register the update below; -> FETCH if count>0 && !hold, else -> IDLE.
//      ld_r=1: acc<=b_r, n<=b_r[3], z<=(b_r==0), c<=0, v<=0.
//      ld_r=0: acc<=alu4.result; c/n/z/v<=alu4 flags, taken unmodified from alu4.
//  - Latency: push accepted at edge E with FSM in IDLE and FIFO empty gives
//    FETCH after E+1, EXEC after E+2, acc/flags updated at E+3, out_valid high for one cycle after E+3.
//  - Throughput: 1 instruction per 2 cycles while the FIFO is non-empty.
//  - Widths: all datapath is 4-bit; ALU carry-out is reported only via c; no wider accumulation.
//  - Pop never occurs when empty; FETCH is entered only with count>0.
//  - Pointer wrap: with FIFO_DEPTH=4, entries 0..3 are reused in order.
// CONFIGURATION
//  ACC_SAT_EN defined: for op 110/111 with alu4 v=1, acc saturates instead of wrapping:
//    acc<=(result[3] ? 4'b0111 : 4'b1000).
//    n and z are recomputed from the saturated value; v=1 and c are still reported from alu4.
//    All other ops are unaffected.
//  ACC_SAT_EN undefined: acc takes alu4.result unmodified (wrap-around).
// TESTING
//  1. Reset, then push ld b=0101 and add b=0011 -> acc=1000, n=1, z=0, v=1, c=0;
//     out_valid pulses twice, 2 cycles apart.
//  2. After 1, push xor b=1000 -> acc=0000, z=1, n=0; then notA -> acc=1111, n=1, z=0.
//  3. hold=1, push 4 instructions -> in_ready=0 after the 4th and a 5th push is not accepted;
//     release hold -> exactly 4 out_valid pulses, results in FIFO order.
//  4. Push ld 0110, and 0011, or 1000 back-to-back across a pointer wrap -> acc 0110, 0010, 1010.
//  5. Assert reset during EXEC of an add -> next cycle acc=0, flags=0, out_valid=0, FIFO empty, busy=0.
//  6. With ACC_SAT_EN: ld 0101, add 0011 -> acc=0111, v=1, n=0. Without it: acc=1000.

Source files
------------

// File: rtl/alu4_acc_ctrl.sv
// Accumulator sequencer around a combinational 4-bit ALU, with an instruction FIFO front end.
// Optional build macro ACC_SAT_EN: add/sub overflow saturates acc instead of wrapping.

module alu4 (
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] result,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v
);
  logic [4:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      3'b000: result = ~a;
      3'b001: result = ~b;
      3'b010: result = a & b;
      3'b011: result = a | b;
      3'b100: result = a ^ b;
      3'b101: result = ~(a ^ b);
      // sub is a + ~b + 1, so c=1 means no borrow
      3'b110: begin
        sum    = {1'b0, a} + {1'b0, ~b} + 5'd1;
        result = sum[3:0];
        c      = sum[4];
        v      = (a[3] != b[3]) && (sum[3] != a[3]);
      end
      default: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[3:0];
        c      = sum[4];
        v      = (a[3] == b[3]) && (sum[3] != a[3]);
      end
    endcase
    n = result[3];
    z = (result == 4'd0);
  end
endmodule

// state | meaning
// IDLE  | waiting for a queued instruction with hold low
// FETCH | pop FIFO head into op_r/b_r/ld_r
// EXEC  | write acc and flags, pulse out_valid next
module alu4_acc_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_ld,
  input  logic [2:0] in_op,
  input  logic [3:0] in_b,
  input  logic       hold,
  output logic [3:0] acc,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v,
  output logic       out_valid,
  output logic       busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;

  logic [1:0]         state;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, push, pop, go;
  logic               ld_r;
  logic [2:0]         op_r;
  logic [3:0]         b_r;
  logic [3:0]         alu_result, acc_next;
  logic               alu_c, alu_n, alu_z, alu_v;

  assign full     = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign pop      = (state == FETCH);
  assign go       = (count != '0) && !hold;
  assign busy     = (state != IDLE) || (count != '0);

  alu4 u_alu4 (
    .op     (op_r),
    .a      (acc),
    .b      (b_r),
    .result (alu_result),
    .c      (alu_c),
    .n      (alu_n),
    .z      (alu_z),
    .v      (alu_v)
  );

  always_comb begin
    acc_next = alu_result;
`ifdef ACC_SAT_EN
    if (op_r[2:1] == 2'b11 && alu_v)
      acc_next = alu_result[3] ? 4'b0111 : 4'b1000;
`endif
  end

  // storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {in_ld, in_op, in_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ld_r      <= 1'b0;
      op_r      <= '0;
      b_r       <= '0;
      acc       <= '0;
      c         <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b0;
      v         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == EXEC);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: if (go) state <= FETCH;
        FETCH: begin
          {ld_r, op_r, b_r} <= fifo_mem[rd_ptr];
          state             <= EXEC;
        end
        EXEC: begin
          if (ld_r) begin
            acc <= b_r;
            n   <= b_r[3];
            z   <= (b_r == 4'd0);
            c   <= 1'b0;
            v   <= 1'b0;
          end else begin
            acc <= acc_next;
            n   <= acc_next[3];
            z   <= (acc_next == 4'd0);
            c   <= alu_c;
            v   <= alu_v;
          end
          state <= go ? FETCH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu4_acc_ctrl.sv
// Directed self-checking bench for alu4_acc_ctrl; expectations follow ACC_SAT_EN when defined.
module tb_alu4_acc_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_ld = 1'b0;
  logic [2:0] in_op = 3'b000;
  logic [3:0] in_b = 4'b0000;
  logic       hold = 1'b0;
  logic [3:0] acc;
  logic       c, n, z, v;
  logic       out_valid;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int push_cyc = 0;

  alu4_acc_ctrl #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ld     (in_ld),
    .in_op     (in_op),
    .in_b      (in_b),
    .hold      (hold),
    .acc       (acc),
    .c         (c),
    .n         (n),
    .z         (z),
    .v         (v),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input logic ld, input logic [2:0] op, input logic [3:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_ld = ld; in_op = op; in_b = b;
    @(posedge clk);
    #1;
    push_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      done = !busy;
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL idle_timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_checks++; if (acc !== 4'b0000) begin n_fail++; $display("FAIL rst_acc: got %b want 0000", acc); end
    n_checks++; if ({c, n, z, v} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {c, n, z, v}); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk); reset = 1'b0; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_ld_add();
    int  t0, t1;
    bit  got = 0;
    logic [3:0] e_acc, e_fl;
`ifdef ACC_SAT_EN
    e_acc = 4'b0111; e_fl = 4'b0001;
`else
    e_acc = 4'b1000; e_fl = 4'b0101;
`endif
    push(1'b1, 3'b000, 4'b0101);
    t0 = push_cyc;
    push(1'b0, 3'b111, 4'b0011);
    for (int k = 0; k < 10 && !got; k++) begin @(posedge clk); #1; got = out_valid; end
    n_checks++; if (!got) begin n_fail++; $display("FAIL ld_timeout: out_valid=%b want 1", out_valid); end
    t1 = cyc;
    n_checks++; if (t1 - t0 !== 3) begin n_fail++; $display("FAIL ld_latency: got %0d want 3", t1 - t0); end
    n_checks++; if (acc !== 4'b0101) begin n_fail++; $display("FAIL ld_acc: got %b want 0101", acc); end
    n_checks++; if ({c, n, z, v} !== 4'b0000) begin n_fail++; $display("FAIL ld_flags: got %b want 0000", {c, n, z, v}); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got %b want 0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_spacing: got %b want 1", out_valid); end
    n_checks++; if (acc !== e_acc) begin n_fail++; $display("FAIL add_acc: got %b want %b", acc, e_acc); end
    n_checks++; if ({c, n, z, v} !== e_fl) begin n_fail++; $display("FAIL add_flags: got %b want %b", {c, n, z, v}, e_fl); end
  endtask

  task automatic test_xor_nota();
    bit got;
    logic [3:0] e_acc0, e_fl0, e_acc1, e_fl1;
`ifdef ACC_SAT_EN
    e_acc0 = 4'b1111; e_fl0 = 4'b0100; e_acc1 = 4'b0000; e_fl1 = 4'b0010;
`else
    e_acc0 = 4'b0000; e_fl0 = 4'b0010; e_acc1 = 4'b1111; e_fl1 = 4'b0100;
`endif
    wait_idle();
    push(1'b0, 3'b100, 4'b1000);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin @(posedge clk); #1; got = out_valid; end
    n_checks++; if (!got) begin n_fail++; $display("FAIL xor_timeout: out_valid=%b want 1", out_valid); end
    n_checks++; if (acc !== e_acc0) begin n_fail++; $display("FAIL xor_acc: got %b want %b", acc, e_acc0); end
    n_checks++; if ({c, n, z, v} !== e_fl0) begin n_fail++; $display("FAIL xor_flags: got %b want %b", {c, n, z, v}, e_fl0); end
    push(1'b0, 3'b000, 4'b0000);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin @(posedge clk); #1; got = out_valid; end
    n_checks++; if (!got) begin n_fail++; $display("FAIL nota_timeout: out_valid=%b want 1", out_valid); end
    n_checks++; if (acc !== e_acc1) begin n_fail++; $display("FAIL nota_acc: got %b want %b", acc, e_acc1); end
    n_checks++; if ({c, n, z, v} !== e_fl1) begin n_fail++; $display("FAIL nota_flags: got %b want %b", {c, n, z, v}, e_fl1); end
  endtask

  task automatic test_hold_full();
    logic [3:0] e_acc [4];
    logic [3:0] e_fl [4];
    int idx = 0;
    e_acc = '{4'b0001, 4'b0010, 4'b1111, 4'b1111};
    e_fl  = '{4'b0000, 4'b0000, 4'b0100, 4'b0100};
    wait_idle();
    @(negedge clk); hold = 1'b1;
    push(1'b1, 3'b000, 4'b0001);
    push(1'b0, 3'b111, 4'b0001);
    push(1'b0, 3'b110, 4'b0011);
    push(1'b0, 3'b011, 4'b0100);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_out_valid: got %b want 0", out_valid); end
    @(negedge clk); in_valid = 1'b1; in_ld = 1'b1; in_b = 4'b1010;
    @(posedge clk); #1; in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_stays: got %b want 0", in_ready); end
    @(negedge clk); hold = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (idx < 4) begin
          n_checks++; if (acc !== e_acc[idx]) begin n_fail++; $display("FAIL hold_acc[%0d]: got %b want %b", idx, acc, e_acc[idx]); end
          n_checks++; if ({c, n, z, v} !== e_fl[idx]) begin n_fail++; $display("FAIL hold_flags[%0d]: got %b want %b", idx, {c, n, z, v}, e_fl[idx]); end
        end
        idx++;
      end
    end
    n_checks++; if (idx !== 4) begin n_fail++; $display("FAIL hold_pulses: got %0d want 4", idx); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e_acc [3];
    logic [3:0] e_fl [3];
    int idx = 0;
    e_acc = '{4'b0110, 4'b0010, 4'b1010};
    e_fl  = '{4'b0000, 4'b0000, 4'b0100};
    wait_idle();
    push(1'b1, 3'b000, 4'b0000);
    push(1'b1, 3'b000, 4'b0000);
    wait_idle();
    push(1'b1, 3'b000, 4'b0110);
    push(1'b0, 3'b010, 4'b0011);
    push(1'b0, 3'b011, 4'b1000);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (idx < 3) begin
          n_checks++; if (acc !== e_acc[idx]) begin n_fail++; $display("FAIL wrap_acc[%0d]: got %b want %b", idx, acc, e_acc[idx]); end
          n_checks++; if ({c, n, z, v} !== e_fl[idx]) begin n_fail++; $display("FAIL wrap_flags[%0d]: got %b want %b", idx, {c, n, z, v}, e_fl[idx]); end
        end
        idx++;
      end
    end
    n_checks++; if (idx !== 3) begin n_fail++; $display("FAIL wrap_pulses: got %0d want 3", idx); end
  endtask

  task automatic test_reset_exec();
    bit seen = 0;
    wait_idle();
    push(1'b1, 3'b000, 4'b0101);
    wait_idle();
    push(1'b0, 3'b111, 4'b0011);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL exec_busy: got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (acc !== 4'b0000) begin n_fail++; $display("FAIL rexec_acc: got %b want 0000", acc); end
    n_checks++; if ({c, n, z, v} !== 4'b0000) begin n_fail++; $display("FAIL rexec_flags: got %b want 0000", {c, n, z, v}); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rexec_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rexec_busy: got %b want 0", busy); end
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid || acc != 4'b0000) seen = 1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rexec_discard: got activity %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_ld_add();
    test_xor_nota();
    test_hold_full();
    test_back_to_back();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
